conv_mac: RTL

//  Downstream consumer of the conv window stage. Accepts one 5x5 pixel window per beat and computes a signed

---
 rtl/conv_mac.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/conv_mac.sv
// 5x5 signed convolution MAC: 3-stage multiply / row-sum / round-shift-clamp pipeline with a
// shadow coefficient bank that swaps into the active bank on an accepted start-of-frame beat.
module conv_mac #(
  parameter int unsigned PIXEL_W = 8,
  parameter int unsigned COEF_W  = 8,
  parameter int unsigned SHIFT   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_tvalid_i,
  input  logic [25*PIXEL_W-1:0]    s_tdata_i,
  input  logic                     s_tuser_i,
  input  logic                     s_tlast_i,
  output logic                     s_tready_o,
  input  logic                     coef_tvalid_i,
  input  logic [COEF_W-1:0]        coef_tdata_i,
  output logic                     coef_tready_o,
  output logic                     coef_pending_o,
  output logic                     m_tvalid_o,
  output logic [PIXEL_W-1:0]       m_tdata_o,
  output logic                     m_tuser_o,
  output logic                     m_tlast_o,
  input  logic                     m_tready_i
);

  localparam int unsigned ACC_W = PIXEL_W + COEF_W + 6;
  localparam int unsigned NTaps = 25;

  localparam logic [0:0] StLoad    = 1'b0;
  localparam logic [0:0] StPending = 1'b1;

  localparam logic signed [COEF_W-1:0] CoefUnity = COEF_W'(1 << SHIFT);
  localparam logic signed [ACC_W-1:0]  RoundK    = ACC_W'((1 << SHIFT) >> 1);
  localparam logic signed [ACC_W-1:0]  PixMax    = ACC_W'((1 << PIXEL_W) - 1);

  logic en;

  logic [0:0] state_q, state_d;
  logic [4:0] idx_q, idx_d;
  logic signed [COEF_W-1:0] shadow_q [NTaps];
  logic signed [COEF_W-1:0] shadow_d [NTaps];
  logic signed [COEF_W-1:0] active_q [NTaps];
  logic signed [COEF_W-1:0] active_d [NTaps];
  logic coef_accept, swap;

  logic v1_q, v1_d, u1_q, u1_d, l1_q, l1_d;
  logic signed [ACC_W-1:0] prod_q [NTaps];
  logic signed [ACC_W-1:0] prod_d [NTaps];

  logic v2_q, v2_d, u2_q, u2_d, l2_q, l2_d;
  logic signed [ACC_W-1:0] row_q [5];
  logic signed [ACC_W-1:0] row_d [5];

  logic m_tvalid_q, m_tvalid_d, m_tuser_q, m_tuser_d, m_tlast_q, m_tlast_d;
  logic [PIXEL_W-1:0] m_tdata_q, m_tdata_d;
  logic signed [ACC_W-1:0] total, rounded, shifted;

  assign en             = !m_tvalid_q || m_tready_i;
  assign s_tready_o     = en;
  assign coef_tready_o  = (state_q == StLoad);
  assign coef_pending_o = (state_q == StPending);
  assign m_tvalid_o     = m_tvalid_q;
  assign m_tdata_o      = m_tdata_q;
  assign m_tuser_o      = m_tuser_q;
  assign m_tlast_o      = m_tlast_q;

  // A word-24 accept and an SOF in the same cycle never swap: state is still StLoad then.
  always_comb begin
    coef_accept = coef_tvalid_i && (state_q == StLoad);
    swap        = (state_q == StPending) && s_tvalid_i && en && s_tuser_i;
    state_d     = state_q;
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    active_d    = active_q;
    if (coef_accept) begin
      shadow_d[idx_q] = coef_tdata_i;
      if (idx_q == 5'(NTaps - 1)) begin
        idx_d   = '0;
        state_d = StPending;
      end else begin
        idx_d = idx_q + 5'd1;
      end
    end
    if (swap) begin
      active_d = shadow_q;
      state_d  = StLoad;
    end
  end

  // S1: the swapping SOF beat itself already multiplies with the incoming bank.
  always_comb begin
    logic signed [ACC_W-1:0]  pix_ext;
    logic signed [ACC_W-1:0]  coef_ext;
    logic signed [COEF_W-1:0] c;
    pix_ext  = '0;
    coef_ext = '0;
    c        = '0;
    v1_d     = v1_q;
    u1_d     = u1_q;
    l1_d     = l1_q;
    prod_d   = prod_q;
    if (en) begin
      v1_d = s_tvalid_i;
      u1_d = s_tvalid_i & s_tuser_i;
      l1_d = s_tvalid_i & s_tlast_i;
      if (s_tvalid_i) begin
        for (int k = 0; k < NTaps; k++) begin
          pix_ext   = ACC_W'(s_tdata_i[k*PIXEL_W +: PIXEL_W]);
          c         = swap ? shadow_q[k] : active_q[k];
          coef_ext  = ACC_W'(c);
          prod_d[k] = pix_ext * coef_ext;
        end
      end
    end
  end

  // S2: row sums.
  always_comb begin
    v2_d  = v2_q;
    u2_d  = u2_q;
    l2_d  = l2_q;
    row_d = row_q;
    if (en) begin
      v2_d = v1_q;
      u2_d = u1_q;
      l2_d = l1_q;
      if (v1_q) begin
        for (int r = 0; r < 5; r++) begin
          row_d[r] = '0;
          for (int c = 0; c < 5; c++) begin
            row_d[r] = row_d[r] + prod_q[r*5 + c];
          end
        end
      end
    end
  end

  // S3: total, round half up, arithmetic shift, clamp to the pixel range.
  always_comb begin
    total = '0;
    for (int r = 0; r < 5; r++) begin
      total = total + row_q[r];
    end
    rounded    = total + RoundK;
    shifted    = rounded >>> SHIFT;
    m_tvalid_d = m_tvalid_q;
    m_tuser_d  = m_tuser_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    if (en) begin
      m_tvalid_d = v2_q;
      m_tuser_d  = u2_q;
      m_tlast_d  = l2_q;
      if (v2_q) begin
        if (shifted < 0) begin
          m_tdata_d = '0;
        end else if (shifted > PixMax) begin
          m_tdata_d = '1;
        end else begin
          m_tdata_d = shifted[PIXEL_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StLoad;
      idx_q      <= '0;
      v1_q       <= 1'b0;
      u1_q       <= 1'b0;
      l1_q       <= 1'b0;
      v2_q       <= 1'b0;
      u2_q       <= 1'b0;
      l2_q       <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tuser_q  <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      for (int k = 0; k < NTaps; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= (k == 12) ? CoefUnity : '0;
        prod_q[k]   <= '0;
      end
      for (int r = 0; r < 5; r++) begin
        row_q[r] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      v1_q       <= v1_d;
      u1_q       <= u1_d;
      l1_q       <= l1_d;
      prod_q     <= prod_d;
      v2_q       <= v2_d;
      u2_q       <= u2_d;
      l2_q       <= l2_d;
      row_q      <= row_d;
      m_tvalid_q <= m_tvalid_d;
      m_tuser_q  <= m_tuser_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
    end
  end

endmodule
